// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the iterative multiply/divide unit.
//   mdu_op_e    : RISC-V M-extension funct3 encoding.
//   mdu_state_e : control FSM states.
//   is_mul / is_signed_a / is_signed_b : operand-handling helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic is_mul(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  // MUL is treated as signed x signed: the low half is identical either way.
  function automatic logic is_signed_a(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
//   remIn   : current partial remainder (always < divisor)
//   bitIn   : next dividend bit shifted into the remainder
//   divisor : divisor magnitude
//   remOut  : next partial remainder
//   qBit    : quotient bit produced by this step
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] remIn,
  input  logic            bitIn,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] remOut,
  output logic            qBit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // shifted < 2*divisor, so one extra bit suffices and the MSB of the
  // difference is a clean borrow flag.
  always_comb begin
    shifted = {remIn, bitIn};
    diff    = shifted - {1'b0, divisor};
    qBit    = ~diff[XLEN];
    remOut  = qBit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RISC-V M-extension multiply/divide unit.
//   Multiply: shift-add, MUL_BITS multiplier bits per cycle.
//   Divide  : restoring, one quotient bit per cycle (only when MDU_DIV_EN
//             is defined; otherwise divide ops complete with out_err=1).
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : operation handshake (in_ready = IDLE && !kill)
//   op, src_a, src_b     : funct3 and operands
//   rd_in / rd_out       : destination tag carried through
//   kill                 : aborts any in-flight operation
//   out_valid/out_ready  : result handshake
//   result, out_err      : result value, unsupported-op flag
//   busy                 : state != IDLE
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            out_err,
  output logic            busy
);

  localparam int unsigned N_MUL = XLEN / MUL_BITS;
  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(N_MUL - 1);

  mdu_state_e state, stateNext;
  mdu_op_e    opIn, opReg;

  logic              accept;
  logic              signA, signB;
  logic [XLEN-1:0]   magA, magB;
  logic [XLEN-1:0]   aMag;
  logic [2*XLEN-1:0] acc;
  logic              negRes;
  logic [CNT_W-1:0]  cnt;

  logic [XLEN+MUL_BITS-1:0] mulSum;
  logic [2*XLEN-1:0]        accMulNext;
  logic [2*XLEN-1:0]        prodFix;
  logic [XLEN-1:0]          fixRes;

  assign opIn   = mdu_op_e'(op);
  assign accept = in_valid && in_ready;

  // Operand magnitudes and result sign, decided at accept time.
  always_comb begin
    signA = is_signed_a(opIn) && src_a[XLEN-1];
    signB = is_signed_b(opIn) && src_b[XLEN-1];
    magA  = signA ? -src_a : src_a;
    magB  = signB ? -src_b : src_b;
  end

`ifdef MDU_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

  logic [XLEN-1:0]   bMag;
  logic              isRemIn, divZero, divOvf, special;
  logic [XLEN-1:0]   specialRes;
  logic [XLEN-1:0]   divRem;
  logic              divQ;
  logic [2*XLEN-1:0] accDivNext;

  always_comb begin
    isRemIn    = (opIn == OP_REM) || (opIn == OP_REMU);
    divZero    = (src_b == '0);
    divOvf     = ((opIn == OP_DIV) || (opIn == OP_REM)) &&
                 (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    special    = !is_mul(opIn) && (divZero || divOvf);
    // Overflow quotient is the most-negative value, i.e. src_a itself.
    specialRes = divZero ? (isRemIn ? src_a : '1) : (isRemIn ? '0 : src_a);
  end

  // acc = {partial remainder, dividend bits shifting out / quotient shifting in}
  mdu_div_step #(.XLEN(XLEN)) uDivStep (
    .remIn   (acc[2*XLEN-1:XLEN]),
    .bitIn   (acc[XLEN-1]),
    .divisor (bMag),
    .remOut  (divRem),
    .qBit    (divQ)
  );

  assign accDivNext = {divRem, acc[XLEN-2:0], divQ};
  assign out_err    = 1'b0;
`else
  logic errReg;
  assign out_err = errReg;
`endif

  // Multiply step: acc = {high partial product, remaining multiplier bits}.
  // The high half never exceeds XLEN+MUL_BITS bits before the shift.
  always_comb begin
    mulSum = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]};
    for (int unsigned i = 0; i < MUL_BITS; i++) begin
      if (acc[i]) mulSum = mulSum + ((XLEN+MUL_BITS)'(aMag) << i);
    end
    accMulNext = {mulSum, acc[XLEN-1:MUL_BITS]};
  end

  // Sign fix-up and half/quotient/remainder selection.
  always_comb begin
    prodFix = negRes ? -acc : acc;
    fixRes  = '0;
    unique case (opReg)
      OP_MUL:                      fixRes = prodFix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fixRes = prodFix[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: fixRes = negRes ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      OP_REM, OP_REMU: fixRes = negRes ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
`endif
      default:                     fixRes = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = (state == ST_IDLE) && !kill;
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_DONE) && !kill;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul(opIn)) stateNext = ST_MUL;
`ifdef MDU_DIV_EN
          else if (special) stateNext = ST_DONE;
          else              stateNext = ST_DIV;
`else
          else              stateNext = ST_DONE;
`endif
        end
      end
      ST_MUL:  if (cnt == MUL_LAST) stateNext = ST_FIX;
`ifdef MDU_DIV_EN
      ST_DIV:  if (cnt == DIV_LAST) stateNext = ST_FIX;
`endif
      ST_FIX:  stateNext = ST_DONE;
      ST_DONE: if (out_ready) stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
    if (kill) stateNext = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opReg  <= OP_MUL;
      aMag   <= '0;
      acc    <= '0;
      negRes <= 1'b0;
      cnt    <= '0;
      result <= '0;
      rd_out <= '0;
`ifdef MDU_DIV_EN
      bMag   <= '0;
`else
      errReg <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            opReg  <= opIn;
            rd_out <= rd_in;
            aMag   <= magA;
            cnt    <= '0;
            // Remainder follows the dividend; everything else is signA^signB.
            negRes <= ((opIn == OP_REM) || (opIn == OP_REMU)) ? signA : (signA ^ signB);
            acc    <= is_mul(opIn) ? {{XLEN{1'b0}}, magB} : {{XLEN{1'b0}}, magA};
`ifdef MDU_DIV_EN
            bMag   <= magB;
            if (special) result <= specialRes;
`else
            errReg <= !is_mul(opIn);
            if (!is_mul(opIn)) result <= '0;
`endif
          end
        end
        ST_MUL: begin
          acc <= accMulNext;
          cnt <= cnt + 1'b1;
        end
`ifdef MDU_DIV_EN
        ST_DIV: begin
          acc <= accDivNext;
          cnt <= cnt + 1'b1;
        end
`endif
        ST_FIX:  result <= fixRes;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized scoreboard bench for mdu_iter (XLEN=32, MUL_BITS=4).
// Honours MDU_DIV_EN the same way the design does.
module tb_mdu_iter;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  rd_in = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        out_err;
  logic        busy;

  mdu_iter #(.XLEN(32), .MUL_BITS(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .rd_out(rd_out), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        err;
    int unsigned lat;
    int unsigned acceptCyc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int stallReq = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic from the RISC-V M rules.
  function automatic exp_t refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    e.err = 1'b0; e.rd = '0; e.acceptCyc = 0;
    e.lat = 10;
    e.res = '0;
    if (o[2] && !DIV_EN) begin
      e.err = 1'b1; e.lat = 1; e.res = '0;
    end else begin
      case (o)
        3'b000: begin p = sa * sb; e.res = p[31:0];  end
        3'b001: begin p = sa * sb; e.res = p[63:32]; end
        3'b010: begin p = sa * ub; e.res = p[63:32]; end
        3'b011: begin p = ua * ub; e.res = p[63:32]; end
        3'b100, 3'b110: begin
          if (b == 32'h0) begin
            e.lat = 1;
            e.res = (o == 3'b100) ? 32'hFFFF_FFFF : a;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lat = 1;
            e.res = (o == 3'b100) ? 32'h8000_0000 : 32'h0;
          end else begin
            e.lat = 34;
            p = (o == 3'b100) ? (sa / sb) : (sa % sb);
            e.res = p[31:0];
          end
        end
        default: begin
          if (b == 32'h0) begin
            e.lat = 1;
            e.res = (o == 3'b101) ? 32'hFFFF_FFFF : a;
          end else begin
            e.lat = 34;
            p = (o == 3'b101) ? (ua / ub) : (ua % ub);
            e.res = p[31:0];
          end
        end
      endcase
    end
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit push, input bit useExp,
                       input logic [31:0] expRes);
    int unsigned t = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout: in_ready still 0 after %0d cycles, required 1", t);
      return;
    end
    in_valid = 1'b1; op = o; src_a = a; src_b = b; rd_in = r;
    if (push) begin
      e = refModel(o, a, b);
      if (useExp && !(o[2] && !DIV_EN)) e.res = expRes;
      e.rd = r;
      e.acceptCyc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Monitor: compares every presented result against the queue head.
  bit seen = 1'b0;
  int stall = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      out_ready = 1'b0;
      seen = 1'b0;
    end else if (out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b1;
      end else begin
        e = sbq[0];
        if (!seen) begin
          seen = 1'b1;
          chk("latency", cyc - e.acceptCyc, e.lat);
          stall = stallReq;
          stallReq = 0;
        end else begin
          chk("hold_in_ready", {31'b0, in_ready}, 32'h0);
        end
        chk("result", result, e.res);
        chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
        chk("out_err", {31'b0, out_err}, {31'b0, e.err});
        if (stall > 0) begin
          stall--;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
          void'(sbq.pop_front());
          seen = 1'b0;
        end
      end
    end else begin
      out_ready = 1'b0;
    end
  end

  task automatic drain();
    int unsigned t = 0;
    while (sbq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", sbq.size(), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
    chk({tag, "_result"}, result, 32'h0);
    chk({tag, "_rd_out"}, {27'b0, rd_out}, 32'h0);
    chk({tag, "_out_err"}, {31'b0, out_err}, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;

    // Directed cases with hand-derived results.
    issue(3'b000, 32'd7, 32'd6, 5'd1, 1, 1, 32'd42);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 1, 1, 32'h4000_0000);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1, 1, 32'hFFFF_FFFF);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1, 1, 32'hFFFF_FFFE);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 1, 1, 32'hFFFF_FFFD);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1, 1, 32'hFFFF_FFFF);
    issue(3'b101, 32'hFFFF_FFFF, 32'h10, 5'd7, 1, 1, 32'h0FFF_FFFF);
    issue(3'b100, 32'd1234, 32'd0, 5'd8, 1, 1, 32'hFFFF_FFFF);
    issue(3'b111, 32'hDEAD_BEEF, 32'd0, 5'd9, 1, 1, 32'hDEAD_BEEF);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1, 1, 32'h8000_0000);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1, 1, 32'h0);
    drain();

    // Consumer stalls three cycles in DONE.
    stallReq = 3;
    issue(3'b000, 32'h1234_5678, 32'h9, 5'd12, 1, 1, 32'hA3D7_0A38);
    drain();

    // kill together with in_valid: not accepted.
    @(negedge clk);
    kill = 1'b1; in_valid = 1'b1; op = 3'b000; src_a = 32'd3; src_b = 32'd3;
    #1 chk("kill_in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk);
    #1 begin kill = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    chk("kill_offer_busy", {31'b0, busy}, 32'h0);

    // kill five cycles into an operation.
    issue(DIV_EN ? 3'b100 : 3'b000, 32'd1000, 32'd7, 5'd13, 0, 0, 32'h0);
    repeat (5) @(negedge clk);
    chk("kill_pre_busy", {31'b0, busy}, 32'h1);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill_post_busy", {31'b0, busy}, 32'h0);
    chk("kill_post_in_ready", {31'b0, in_ready}, 32'h1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw = saw | out_valid;
    end
    chk("kill_no_valid", {31'b0, saw}, 32'h0);

    // Reset pulse mid-multiply.
    issue(3'b001, 32'hCAFE_F00D, 32'h1357_9BDF, 5'd14, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkIdleOutputs("midreset");
    reset = 1'b0;

    // Randomized traffic with biased special operands.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 100)) - 32'd50; rb = 32'($urandom_range(0, 20)) - 32'd10; end
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) stallReq = int'($urandom_range(1, 2));
      issue(ro, ra, rb, 5'($urandom_range(0, 31)), 1, 0, 32'h0);
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
